serial_subtractor_64bit: RTL and testbench

SERIAL_SUBTRACTOR_64BIT -- requirements
Module: serial_subtractor_64bit

---
 rtl/serial_subtractor_64bit.sv | 116 +++++++++++
 tb/tb_serial_subtractor_64bit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_64bit.sv
// Bit-serial a - b - bin: one full-subtractor cell and one borrow flop, LSB first.
// Latency: done pulses in the cycle that begins 64 edges after the edge that accepted start.
// Backpressure: start is accepted only in IDLE or DONE; during RUN it is ignored (busy=1).
module serial_subtractor_64bit #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;   // bits 0..62 collect here; bit 63 goes straight to diff
    logic             br;
    logic [CW-1:0]    cnt;
    logic             a_msb;
    logic             b_msb;

    logic load;
    logic ai;
    logic bi;
    logic d;
    logic br_nxt;

    // Per-bit full-subtractor cell operating on the current LSBs
    assign ai     = a_sr[0];
    assign bi     = b_sr[0];
    assign d      = ai ^ bi ^ br;
    assign br_nxt = (~ai & bi) | (~(ai ^ bi) & br);

    // A new job is taken from IDLE, or straight out of DONE for back-to-back operation
    assign load = start && ((state == S_IDLE) || (state == S_DONE));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (cnt == LAST) state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs are pure decodes of the registered state
    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
    end

    // Operand load, serial shift, and result capture on the final bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (load) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= bin;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            cnt   <= '0;
        end else if (state == S_RUN) begin
            a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
            res_sr <= {d, res_sr[WIDTH-2:1]};
            br     <= br_nxt;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) begin
                // d here is the sign bit of the result; the latched signs give the overflow
                diff <= {d, res_sr};
                bout <= br_nxt;
                ovf  <= (a_msb != b_msb) && (d != a_msb);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor_64bit.sv
// Bench for serial_subtractor_64bit: transaction-level reference model plus directed literal checks.
// Latency: model publishes each result 64 edges after its accept edge.
// Backpressure: model accepts start only when no job is in flight.
module tb_serial_subtractor_64bit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        bin = 1'b0;
    logic        busy;
    logic        done;
    logic [63:0] diff;
    logic        bout;
    logic        ovf;

    int n_vec = 0;
    int n_err = 0;

    serial_subtractor_64bit #(.WIDTH(64)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a job is accepted when idle, its answer appears 64 edges later
    int          m_age = -1;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [63:0] m_diff = '0;
    logic        m_bout = 1'b0;
    logic        m_ovf = 1'b0;
    logic [63:0] p_diff;
    logic        p_bout;
    logic        p_ovf;

    initial begin
        logic [64:0] full;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_age  = -1;
                m_busy = 1'b0;
                m_done = 1'b0;
                m_diff = '0;
                m_bout = 1'b0;
                m_ovf  = 1'b0;
            end else begin
                if (m_age >= 0) begin
                    m_age++;
                    if (m_age == 64) begin
                        m_age  = -1;
                        m_done = 1'b1;
                        m_diff = p_diff;
                        m_bout = p_bout;
                        m_ovf  = p_ovf;
                    end
                end else begin
                    m_done = 1'b0;
                    if (start) begin
                        full   = {1'b0, a} - {1'b0, b} - {64'd0, bin};
                        p_diff = full[63:0];
                        p_bout = full[64];
                        p_ovf  = (a[63] != b[63]) && (full[63] != a[63]);
                        m_age  = 0;
                    end
                end
                m_busy = (m_age >= 0);
            end
            #1;
            chk("busy", {63'd0, busy}, {63'd0, m_busy});
            chk("done", {63'd0, done}, {63'd0, m_done});
            chk("diff", diff, m_diff);
            chk("bout", {63'd0, bout}, {63'd0, m_bout});
            chk("ovf",  {63'd0, ovf},  {63'd0, m_ovf});
        end
    end

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1) begin
            if (n >= 100) begin
                n_vec++;
                n_err++;
                $display("FAIL done_timeout: got no done within %0d cycles, required done", n);
                return;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input logic [63:0] ta, input logic [63:0] tb_, input logic tbin);
        @(negedge clk);
        a = ta; b = tb_; bin = tbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; bin = 1'($urandom);
        wait_done();
    endtask

    task automatic chk_res(input string nm, input logic [63:0] ed, input logic eb, input logic eo);
        chk({nm, "_diff"}, diff, ed);
        chk({nm, "_bout"}, {63'd0, bout}, {63'd0, eb});
        chk({nm, "_ovf"},  {63'd0, ovf},  {63'd0, eo});
    endtask

    initial begin
        logic pinned;
        int   busy_cnt;
        logic [63:0] ra;
        logic [63:0] rb;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk_res("rst", 64'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Basic: 10 - 3, and busy must last exactly 64 cycles
        @(negedge clk);
        a = 64'hA; b = 64'h3; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = '1; b = '1; bin = 1'b1;
        busy_cnt = 0;
        while (busy === 1'b1 && busy_cnt < 100) begin
            busy_cnt++;
            @(negedge clk);
        end
        chk("basic_busy_len", 64'(busy_cnt), 64'd64);
        chk("basic_done", {63'd0, done}, 64'd1);
        chk_res("basic", 64'h7, 1'b0, 1'b0);

        // Borrow and wrap, then equal operands
        run_op(64'h0, 64'h0, 1'b1);
        chk_res("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        run_op(64'h5, 64'h5, 1'b0);
        chk_res("equal", 64'h0, 1'b0, 1'b0);

        // Signed overflow both directions
        run_op(64'h8000_0000_0000_0000, 64'h1, 1'b0);
        chk_res("ovf_neg", 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        chk_res("ovf_pos", 64'h8000_0000_0000_0000, 1'b1, 1'b1);

        // start held high, inputs changing every cycle
        @(negedge clk);
        a = 64'h100; b = 64'h1; bin = 1'b1; start = 1'b1;
        pinned = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (done === 1'b1 && !pinned) begin
                chk_res("held_first", 64'hFE, 1'b0, 1'b0);
                pinned = 1'b1;
            end
            a = {$urandom, $urandom}; b = {$urandom, $urandom}; bin = 1'($urandom);
        end
        chk("held_pinned", {63'd0, pinned}, 64'd1);
        start = 1'b0;
        wait_done();

        // Reset in the middle of RUN
        @(negedge clk);
        a = 64'h1234; b = 64'h34; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk_res("midrst", 64'd0, 1'b0, 1'b0);
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        repeat (70) begin
            @(negedge clk);
            chk("midrst_nodone", {63'd0, done}, 64'd0);
        end
        run_op(64'h10, 64'h1, 1'b0);
        chk_res("after_rst", 64'hF, 1'b0, 1'b0);

        // Random operands, gaps of 0..2 cycles, gap 0 restarts on the DONE cycle
        @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: ra = '0;
                1: rb = '1;
                2: rb = ra;
                default: ;
            endcase
            a = ra; b = rb; bin = 1'($urandom); start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            a = {$urandom, $urandom}; b = {$urandom, $urandom}; bin = 1'($urandom);
            wait_done();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
